// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared types, sizes and helpers for the div_ctrl radix-2 restoring divider
package div_ctrl_pkg;
  localparam int DATA_W = 32;
  localparam int DIV_ITER = 32;
  localparam int CNT_W = $clog2(DIV_ITER);
  typedef logic reset_status_t;
  localparam reset_status_t RST_ENABLE = 1'b0;
  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;
  typedef enum logic [1:0] {IDLE, BUSY, DIVZERO, DONE} div_state_t;
  function automatic logic [DATA_W-1:0] neg_if(input logic n, input logic [DATA_W-1:0] v);
    return n ? -v : v;
  endfunction
endpackage

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: EX-stage divide request/response bundle
interface div_ctrl_if;
  import div_ctrl_pkg::*;
  logic start;
  logic is_signed;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic annul;
  hilo_t result;
  logic ready;
  logic stall_req;
  modport master (
    output start, is_signed, dividend, divisor, annul,
    input  result, ready, stall_req
  );
  modport slave (
    input  start, is_signed, dividend, divisor, annul,
    output result, ready, stall_req
  );
endinterface

// File: rtl/div_ctrl_step.sv
// div_ctrl_step: one restoring-division iteration (shift in next dividend bit, trial subtract)
module div_ctrl_step
  import div_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] rem,
  input  logic              quo_msb,
  input  logic [DATA_W-1:0] dvs,
  output logic [DATA_W-1:0] rem_nxt,
  output logic              q_bit
);
  logic [DATA_W:0] shifted;
  logic [DATA_W-1:0] trial;
  assign shifted = {rem, quo_msb};
  assign trial = shifted[DATA_W-1:0] - dvs;
  assign q_bit = shifted >= {1'b0, dvs};
  assign rem_nxt = q_bit ? trial : shifted[DATA_W-1:0];
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle DIV/DIVU controller; define DIV_ZERO_FASTPATH_EN to short-circuit zero divisors
module div_ctrl
  import div_ctrl_pkg::*;
(
  input logic          clk,
  input reset_status_t rst,
  div_ctrl_if.slave    bus
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);
  div_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] rem, quo, dvs, rem_nxt;
  logic q_neg, r_neg, q_bit, accept, last, div_zero;
`ifdef DIV_ZERO_FASTPATH_EN
  assign div_zero = bus.divisor == '0;
`else
  assign div_zero = 1'b0;
`endif
  div_ctrl_step u_step (
    .rem     (rem),
    .quo_msb (quo[DATA_W-1]),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );
  // next-state selection and the combinational pipeline stall request
  always_comb begin
    accept = state == IDLE && bus.start && !bus.annul;
    last = cnt == CNT_LAST;
    bus.stall_req = accept || state == BUSY || state == DIVZERO;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? (div_zero ? DIVZERO : BUSY) : IDLE;
      BUSY:    state_nxt = bus.annul ? IDLE : (last ? DONE : BUSY);
      DIVZERO: state_nxt = bus.annul ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) state <= (rst == RST_ENABLE) ? IDLE : state_nxt;
  // operand capture, shift/subtract iterations and the one-cycle result presentation
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      bus.result <= '0;
      bus.ready <= 1'b0;
    end else begin
      bus.ready <= 1'b0;
      bus.result <= '0;
      if (accept) begin
        quo <= neg_if(bus.is_signed & bus.dividend[DATA_W-1], bus.dividend);
        dvs <= neg_if(bus.is_signed & bus.divisor[DATA_W-1], bus.divisor);
        q_neg <= bus.is_signed & (bus.dividend[DATA_W-1] ^ bus.divisor[DATA_W-1]);
        r_neg <= bus.is_signed & bus.dividend[DATA_W-1];
        rem <= '0;
        cnt <= '0;
      end
      if (state == BUSY && !bus.annul) begin
        rem <= rem_nxt;
        quo <= {quo[DATA_W-2:0], q_bit};
        cnt <= cnt + 1'b1;
        if (last) begin
          bus.ready <= 1'b1;
          bus.result <= {neg_if(r_neg, rem_nxt), neg_if(q_neg, {quo[DATA_W-2:0], q_bit})};
        end
      end
      if (state == DIVZERO && !bus.annul) bus.ready <= 1'b1;
    end
  end
endmodule
